// File: rtl/mccpu_cu.sv
// Multi-cycle MIPS-subset control unit: a five-state FSM (IF/ID/EXE/MEM/WB)
// whose datapath controls decode combinationally from state, op, func and z.
module mccpu_cu (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    output logic       wpc,
    output logic       wir,
    output logic       wmem,
    output logic       wreg,
    output logic       iord,
    output logic       regrt,
    output logic       m2reg,
    output logic       shift,
    output logic       sext,
    output logic       jal,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [3:0] aluc,
    output logic [1:0] pcsource,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IF  = 3'b000,
        S_ID  = 3'b001,
        S_EXE = 3'b010,
        S_MEM = 3'b011,
        S_WB  = 3'b100
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    state_t state_q, state_d, dec_state;

    // Instruction classification
    logic       r_type, r_alu, r_jr, r_shift;
    logic [3:0] r_aluc;
    logic       i_alu, i_sext;
    logic [3:0] i_aluc;
    logic       is_lw, is_sw, is_beq, is_bne, is_j, is_jal, supported;

    assign r_type = (op == OP_RTYPE);
    assign is_lw  = (op == OP_LW);
    assign is_sw  = (op == OP_SW);
    assign is_beq = (op == OP_BEQ);
    assign is_bne = (op == OP_BNE);
    assign is_j   = (op == OP_J);
    assign is_jal = (op == OP_JAL);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        r_alu   = 1'b0;
        r_jr    = 1'b0;
        r_shift = 1'b0;
        r_aluc  = ALU_ADD;
        if (r_type) begin
            case (func)
                6'b100000: begin r_alu = 1'b1; r_aluc = ALU_ADD; end
                6'b100010: begin r_alu = 1'b1; r_aluc = ALU_SUB; end
                6'b100100: begin r_alu = 1'b1; r_aluc = ALU_AND; end
                6'b100101: begin r_alu = 1'b1; r_aluc = ALU_OR;  end
                6'b100110: begin r_alu = 1'b1; r_aluc = ALU_XOR; end
                6'b000000: begin r_alu = 1'b1; r_shift = 1'b1; r_aluc = ALU_SLL; end
                6'b000010: begin r_alu = 1'b1; r_shift = 1'b1; r_aluc = ALU_SRL; end
                6'b000011: begin r_alu = 1'b1; r_shift = 1'b1; r_aluc = ALU_SRA; end
                6'b001000: r_jr = 1'b1;
                default:   r_alu = 1'b0;
            endcase
        end
    end

    // Immediate forms; only address and addi arithmetic sign-extend.
    always_comb begin
        i_alu  = 1'b1;
        i_sext = 1'b0;
        i_aluc = ALU_ADD;
        case (op)
            OP_ADDI: i_sext = 1'b1;
            OP_LW:   i_sext = 1'b1;
            OP_SW:   i_sext = 1'b1;
            OP_ANDI: i_aluc = ALU_AND;
            OP_ORI:  i_aluc = ALU_OR;
            OP_XORI: i_aluc = ALU_XOR;
            OP_LUI:  i_aluc = ALU_LUI;
            default: i_alu  = 1'b0;
        endcase
    end

    assign supported = r_alu | r_jr | i_alu | is_beq | is_bne | is_j | is_jal;

    // Reset decodes as IF so the datapath sees a sane fetch setup.
    assign dec_state = reset ? S_IF : state_q;

    always_comb begin
        state_d  = S_IF;
        wpc      = 1'b0;
        wir      = 1'b0;
        wmem     = 1'b0;
        wreg     = 1'b0;
        iord     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        shift    = 1'b0;
        sext     = 1'b0;
        jal      = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluc     = ALU_ADD;
        pcsource = 2'b00;
        case (dec_state)
            S_IF: begin
                wpc     = 1'b1;
                wir     = 1'b1;
                alusrcb = 2'b01;
                state_d = S_ID;
            end
            S_ID: begin
                alusrcb = 2'b11;
                sext    = 1'b1;
                if (is_j) begin
                    wpc      = 1'b1;
                    pcsource = 2'b11;
                end else if (r_jr) begin
                    wpc      = 1'b1;
                    pcsource = 2'b10;
                end else if (is_jal) begin
                    wpc      = 1'b1;
                    wreg     = 1'b1;
                    jal      = 1'b1;
                    pcsource = 2'b11;
                end else if (supported) begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                if (r_alu) begin
                    alusrca = 1'b1;
                    aluc    = r_aluc;
                    shift   = r_shift;
                    state_d = S_WB;
                end else if (i_alu) begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    aluc    = i_aluc;
                    sext    = i_sext;
                    state_d = (is_lw || is_sw) ? S_MEM : S_WB;
                end else if (is_beq || is_bne) begin
                    alusrca  = 1'b1;
                    aluc     = ALU_SUB;
                    pcsource = 2'b01;
                    wpc      = is_beq ? z : ~z;
                end
            end
            S_MEM: begin
                iord = 1'b1;
                if (is_sw) wmem = 1'b1;
                if (is_lw) state_d = S_WB;
            end
            S_WB: begin
                wreg  = 1'b1;
                regrt = ~r_type;
                m2reg = is_lw;
            end
            default: state_d = S_IF;
        endcase
        if (reset) begin
            wpc  = 1'b0;
            wir  = 1'b0;
            wmem = 1'b0;
            wreg = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: tb/tb_mccpu_cu.sv
// Table-driven bench for mccpu_cu: per-cycle {inputs, expected state/controls}
// rows, plus hand sequences for reset during MEM and z changing within EXE.
module tb_mccpu_cu;

    logic       clock, reset, z;
    logic [5:0] op, func;
    logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, sext, jal, alusrca;
    logic [1:0] alusrcb, pcsource;
    logic [3:0] aluc;
    logic [2:0] state;

    mccpu_cu dut (
        .clock(clock), .reset(reset), .op(op), .func(func), .z(z),
        .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord),
        .regrt(regrt), .m2reg(m2reg), .shift(shift), .sext(sext), .jal(jal),
        .alusrca(alusrca), .alusrcb(alusrcb), .aluc(aluc), .pcsource(pcsource),
        .state(state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {wpc,wir,wmem,wreg}_{iord,regrt,m2reg,shift}_{sext,jal,alusrca}_{alusrcb}_{aluc}_{pcsource}
    logic [18:0] act_ctl;
    assign act_ctl = {wpc, wir, wmem, wreg, iord, regrt, m2reg, shift,
                      sext, jal, alusrca, alusrcb, aluc, pcsource};

    localparam logic [18:0] C_RST     = 19'b0000_0000_000_01_0000_00;
    localparam logic [18:0] C_IF      = 19'b1100_0000_000_01_0000_00;
    localparam logic [18:0] C_ID      = 19'b0000_0000_100_11_0000_00;
    localparam logic [18:0] C_ID_J    = 19'b1000_0000_100_11_0000_11;
    localparam logic [18:0] C_ID_JR   = 19'b1000_0000_100_11_0000_10;
    localparam logic [18:0] C_ID_JAL  = 19'b1001_0000_110_11_0000_11;
    localparam logic [18:0] C_EX_ADD  = 19'b0000_0000_001_00_0000_00;
    localparam logic [18:0] C_EX_SUB  = 19'b0000_0000_001_00_0100_00;
    localparam logic [18:0] C_EX_AND  = 19'b0000_0000_001_00_0001_00;
    localparam logic [18:0] C_EX_SLL  = 19'b0000_0001_001_00_0011_00;
    localparam logic [18:0] C_EX_SRL  = 19'b0000_0001_001_00_0111_00;
    localparam logic [18:0] C_EX_SRA  = 19'b0000_0001_001_00_1111_00;
    localparam logic [18:0] C_EX_ADDI = 19'b0000_0000_101_10_0000_00;
    localparam logic [18:0] C_EX_ORI  = 19'b0000_0000_001_10_0101_00;
    localparam logic [18:0] C_EX_XORI = 19'b0000_0000_001_10_0010_00;
    localparam logic [18:0] C_EX_LUI  = 19'b0000_0000_001_10_0110_00;
    localparam logic [18:0] C_EX_BR1  = 19'b1000_0000_001_00_0100_01;
    localparam logic [18:0] C_EX_BR0  = 19'b0000_0000_001_00_0100_01;
    localparam logic [18:0] C_MEM_LW  = 19'b0000_1000_000_00_0000_00;
    localparam logic [18:0] C_MEM_SW  = 19'b0010_1000_000_00_0000_00;
    localparam logic [18:0] C_WB_R    = 19'b0001_0000_000_00_0000_00;
    localparam logic [18:0] C_WB_I    = 19'b0001_0100_000_00_0000_00;
    localparam logic [18:0] C_WB_LW   = 19'b0001_0110_000_00_0000_00;

    localparam logic [2:0] S_IF = 3'b000, S_ID = 3'b001, S_EX = 3'b010, S_MEM = 3'b011, S_WB = 3'b100;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_ORI = 6'b001101, OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LUI = 6'b001111, OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BAD = 6'b111111;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_SLL = 6'b000000, F_SRL = 6'b000010, F_SRA = 6'b000011;
    localparam logic [5:0] F_JR = 6'b001000, F_BAD = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  func;
        logic        z;
        logic [2:0]  exp_state;
        logic [18:0] exp_ctl;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic r, input logic [5:0] o, input logic [5:0] f,
                        input logic zz, input logic [2:0] st, input logic [18:0] c);
        vec_t v;
        v.rst = r; v.op = o; v.func = f; v.z = zz; v.exp_state = st; v.exp_ctl = c;
        vecs.push_back(v);
    endtask

    // Drive inputs mid-cycle and compare after the combinational decode settles.
    task automatic drive_check(input string tag, input logic r, input logic [5:0] o,
                               input logic [5:0] f, input logic zz,
                               input logic [2:0] st, input logic [18:0] c);
        reset = r; op = o; func = f; z = zz;
        #2;
        check({tag, " state"}, {29'd0, state}, {29'd0, st});
        check({tag, " ctl"}, {13'd0, act_ctl}, {13'd0, c});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; op = OP_R; func = F_ADD; z = 1'b0;
        step();

        push(1, OP_R, F_ADD, 0, S_IF, C_RST);
        push(1, OP_R, F_ADD, 0, S_IF, C_RST);
        push(0, OP_R, F_ADD, 0, S_IF, C_IF);
        push(0, OP_R, F_ADD, 0, S_ID, C_ID);
        push(0, OP_R, F_ADD, 0, S_EX, C_EX_ADD);
        push(0, OP_R, F_ADD, 0, S_WB, C_WB_R);
        push(0, OP_R, F_SUB, 0, S_IF, C_IF);
        push(0, OP_R, F_SUB, 0, S_ID, C_ID);
        push(0, OP_R, F_SUB, 1, S_EX, C_EX_SUB);
        push(0, OP_R, F_SUB, 0, S_WB, C_WB_R);
        push(0, OP_R, F_AND, 0, S_IF, C_IF);
        push(0, OP_R, F_AND, 0, S_ID, C_ID);
        push(0, OP_R, F_AND, 0, S_EX, C_EX_AND);
        push(0, OP_R, F_AND, 0, S_WB, C_WB_R);
        push(0, OP_R, F_SLL, 0, S_IF, C_IF);
        push(0, OP_R, F_SLL, 0, S_ID, C_ID);
        push(0, OP_R, F_SLL, 0, S_EX, C_EX_SLL);
        push(0, OP_R, F_SLL, 0, S_WB, C_WB_R);
        push(0, OP_R, F_SRL, 0, S_IF, C_IF);
        push(0, OP_R, F_SRL, 0, S_ID, C_ID);
        push(0, OP_R, F_SRL, 0, S_EX, C_EX_SRL);
        push(0, OP_R, F_SRL, 0, S_WB, C_WB_R);
        push(0, OP_R, F_SRA, 0, S_IF, C_IF);
        push(0, OP_R, F_SRA, 0, S_ID, C_ID);
        push(0, OP_R, F_SRA, 0, S_EX, C_EX_SRA);
        push(0, OP_R, F_SRA, 0, S_WB, C_WB_R);
        push(0, OP_LW, F_SLL, 0, S_IF, C_IF);
        push(0, OP_LW, F_SLL, 0, S_ID, C_ID);
        push(0, OP_LW, F_SLL, 0, S_EX, C_EX_ADDI);
        push(0, OP_LW, F_SLL, 0, S_MEM, C_MEM_LW);
        push(0, OP_LW, F_SLL, 0, S_WB, C_WB_LW);
        push(0, OP_SW, F_SLL, 0, S_IF, C_IF);
        push(0, OP_SW, F_SLL, 0, S_ID, C_ID);
        push(0, OP_SW, F_SLL, 0, S_EX, C_EX_ADDI);
        push(0, OP_SW, F_SLL, 0, S_MEM, C_MEM_SW);
        push(0, OP_ADDI, F_ADD, 0, S_IF, C_IF);
        push(0, OP_ADDI, F_ADD, 0, S_ID, C_ID);
        push(0, OP_ADDI, F_ADD, 0, S_EX, C_EX_ADDI);
        push(0, OP_ADDI, F_ADD, 0, S_WB, C_WB_I);
        push(0, OP_ORI, F_ADD, 0, S_IF, C_IF);
        push(0, OP_ORI, F_ADD, 0, S_ID, C_ID);
        push(0, OP_ORI, F_ADD, 0, S_EX, C_EX_ORI);
        push(0, OP_ORI, F_ADD, 0, S_WB, C_WB_I);
        push(0, OP_XORI, F_ADD, 0, S_IF, C_IF);
        push(0, OP_XORI, F_ADD, 0, S_ID, C_ID);
        push(0, OP_XORI, F_ADD, 0, S_EX, C_EX_XORI);
        push(0, OP_XORI, F_ADD, 0, S_WB, C_WB_I);
        push(0, OP_LUI, F_ADD, 0, S_IF, C_IF);
        push(0, OP_LUI, F_ADD, 0, S_ID, C_ID);
        push(0, OP_LUI, F_ADD, 0, S_EX, C_EX_LUI);
        push(0, OP_LUI, F_ADD, 0, S_WB, C_WB_I);
        push(0, OP_BEQ, F_ADD, 1, S_IF, C_IF);
        push(0, OP_BEQ, F_ADD, 1, S_ID, C_ID);
        push(0, OP_BEQ, F_ADD, 1, S_EX, C_EX_BR1);
        push(0, OP_BEQ, F_ADD, 0, S_IF, C_IF);
        push(0, OP_BEQ, F_ADD, 0, S_ID, C_ID);
        push(0, OP_BEQ, F_ADD, 0, S_EX, C_EX_BR0);
        push(0, OP_BNE, F_ADD, 1, S_IF, C_IF);
        push(0, OP_BNE, F_ADD, 1, S_ID, C_ID);
        push(0, OP_BNE, F_ADD, 1, S_EX, C_EX_BR0);
        push(0, OP_BNE, F_ADD, 0, S_IF, C_IF);
        push(0, OP_BNE, F_ADD, 0, S_ID, C_ID);
        push(0, OP_BNE, F_ADD, 0, S_EX, C_EX_BR1);
        push(0, OP_J, F_ADD, 0, S_IF, C_IF);
        push(0, OP_J, F_ADD, 0, S_ID, C_ID_J);
        push(0, OP_R, F_JR, 0, S_IF, C_IF);
        push(0, OP_R, F_JR, 0, S_ID, C_ID_JR);
        push(0, OP_JAL, F_ADD, 0, S_IF, C_IF);
        push(0, OP_JAL, F_ADD, 0, S_ID, C_ID_JAL);
        push(0, OP_BAD, F_ADD, 0, S_IF, C_IF);
        push(0, OP_BAD, F_ADD, 0, S_ID, C_ID);
        push(0, OP_R, F_BAD, 0, S_IF, C_IF);
        push(0, OP_R, F_BAD, 0, S_ID, C_ID);

        foreach (vecs[i]) begin
            drive_check($sformatf("row%0d", i), vecs[i].rst, vecs[i].op, vecs[i].func,
                        vecs[i].z, vecs[i].exp_state, vecs[i].exp_ctl);
            step();
        end

        // sw interrupted by reset in MEM: no store that cycle, IF on the edge.
        drive_check("sw_rst if", 0, OP_SW, F_ADD, 0, S_IF, C_IF);   step();
        drive_check("sw_rst id", 0, OP_SW, F_ADD, 0, S_ID, C_ID);   step();
        drive_check("sw_rst ex", 0, OP_SW, F_ADD, 0, S_EX, C_EX_ADDI); step();
        drive_check("sw_rst mem", 1, OP_SW, F_ADD, 0, S_MEM, C_RST); step();
        drive_check("sw_rst held", 1, OP_SW, F_ADD, 0, S_IF, C_RST); step();
        drive_check("sw_rst rel", 0, OP_SW, F_ADD, 0, S_IF, C_IF);  step();
        drive_check("sw_rst id2", 0, OP_SW, F_ADD, 0, S_ID, C_ID);  step();

        // lw interrupted by reset in MEM, then a fresh add completes normally.
        drive_check("lw_rst ex", 0, OP_LW, F_ADD, 0, S_EX, C_EX_ADDI); step();
        drive_check("lw_rst mem", 1, OP_LW, F_ADD, 0, S_MEM, C_RST); step();
        drive_check("lw_rst rel", 0, OP_R, F_ADD, 0, S_IF, C_IF);   step();
        drive_check("lw_rst id", 0, OP_R, F_ADD, 0, S_ID, C_ID);    step();
        drive_check("lw_rst ex2", 0, OP_R, F_ADD, 0, S_EX, C_EX_ADD); step();
        drive_check("lw_rst wb", 0, OP_R, F_ADD, 0, S_WB, C_WB_R);  step();

        // wpc follows z within the branch EXE cycle.
        drive_check("ztog if", 0, OP_BEQ, F_ADD, 0, S_IF, C_IF);    step();
        drive_check("ztog id", 0, OP_BEQ, F_ADD, 0, S_ID, C_ID);    step();
        drive_check("ztog beq z1", 0, OP_BEQ, F_ADD, 1, S_EX, C_EX_BR1);
        drive_check("ztog beq z0", 0, OP_BEQ, F_ADD, 0, S_EX, C_EX_BR0);
        drive_check("ztog bne z0", 0, OP_BNE, F_ADD, 0, S_EX, C_EX_BR1);
        step();
        drive_check("ztog back", 0, OP_R, F_ADD, 0, S_IF, C_IF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
